// File: rtl/input_conditioner_multi.sv
// input_conditioner_multi: per-channel 2-FF synchroniser, debouncer and one-cycle press strobe.
// Optional auto-repeat for held keys is built only when INPUT_COND_REPEAT_EN is defined.
module input_conditioner_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] A,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic                any_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("input_conditioner_multi: all parameters must be >= 1");
    end

    logic [CHANNELS-1:0] w_raw;
    logic [CHANNELS-1:0] w_accept;
    logic [CHANNELS-1:0] r_s1;
    logic [CHANNELS-1:0] r_s2;
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_pulse;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

`ifdef INPUT_COND_REPEAT_EN
    localparam int              RC_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RC_W      = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD - 1);

    logic [RC_W-1:0] r_rc [CHANNELS];
`endif

    // Normalise polarity so that 1 always means pressed from here on.
    always_comb begin
        w_raw = A ^ {CHANNELS{POL}};
        w_accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_accept[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
`ifdef INPUT_COND_REPEAT_EN
                r_rc[i]  <= '0;
`endif
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pulse[i] <= 1'b0;
                // Any sample matching the accepted level restarts the stability count.
                if (w_accept[i] || (r_s2[i] == r_level[i])) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                if (w_accept[i]) begin
                    r_level[i] <= r_s2[i];
                    r_pulse[i] <= r_s2[i];
                end
`ifdef INPUT_COND_REPEAT_EN
                // A level change wins over a due repeat, so release never pulses.
                if (w_accept[i]) begin
                    r_rc[i] <= r_s2[i] ? RC_DELAY : '0;
                end else if (r_level[i]) begin
                    if (r_rc[i] == '0) begin
                        r_pulse[i] <= 1'b1;
                        r_rc[i]    <= RC_PERIOD;
                    end else begin
                        r_rc[i] <= r_rc[i] - 1'b1;
                    end
                end else begin
                    r_rc[i] <= '0;
                end
`endif
            end
        end
    end

    assign level     = r_level;
    assign pulse     = r_pulse;
    assign any_pulse = |r_pulse;

endmodule

// File: tb/tb_input_conditioner_multi.sv
// Bench for input_conditioner_multi: directed latency/bounce/reset cases plus random stimulus
// checked every cycle against a sample-window reference model.
module tb_input_conditioner_multi;
  localparam int CH = 4;
  localparam int DB = 4;
  localparam int AL = 1;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [CH-1:0] A = '1;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic          any_pulse;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  input_conditioner_multi #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .A(A),
    .level(level), .pulse(pulse), .any_pulse(any_pulse)
  );

  // clock
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a two-sample delay line; a new level is accepted
  // once the last DB delayed samples all disagree with the current accepted level.
  bit sync_q [CH][$];
  bit win_q  [CH][$];
  bit m_level [CH];
  bit m_pulse [CH];
  int m_press_edge [CH];
  int edge_no = 0;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      sync_q[c].delete();
      sync_q[c].push_back(1'b0);
      sync_q[c].push_back(1'b0);
      win_q[c].delete();
      m_level[c] = 1'b0;
      m_pulse[c] = 1'b0;
      m_press_edge[c] = 0;
    end
  endfunction

  function automatic void model_step(input logic [CH-1:0] a);
    bit p;
    bit seen;
    bit all_diff;
    int dt;
    edge_no++;
    for (int c = 0; c < CH; c++) begin
      p = a[c] ^ (AL != 0);
      seen = sync_q[c].pop_front();
      sync_q[c].push_back(p);
      win_q[c].push_back(seen);
      if (win_q[c].size() > DB) void'(win_q[c].pop_front());
      all_diff = (win_q[c].size() == DB);
      foreach (win_q[c][k]) if (win_q[c][k] == m_level[c]) all_diff = 1'b0;
      m_pulse[c] = 1'b0;
      dt = edge_no - m_press_edge[c];
      if (all_diff) begin
        m_level[c] = seen;
        if (seen) begin
          m_pulse[c] = 1'b1;
          m_press_edge[c] = edge_no;
        end
      end
`ifdef INPUT_COND_REPEAT_EN
      else if (m_level[c]) begin
        if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) m_pulse[c] = 1'b1;
      end
`endif
    end
  endfunction

  // Scoreboard: update the model on each active edge, compare shortly after.
  initial begin
    logic [CH-1:0] e_lvl;
    logic [CH-1:0] e_pls;
    model_reset();
    forever begin
      @(posedge Clock);
      if (Reset) model_reset();
      else model_step(A);
      #1;
      if (mon_en) begin
        for (int c = 0; c < CH; c++) begin
          e_lvl[c] = m_level[c];
          e_pls[c] = m_pulse[c];
        end
        check_eq("model_level", 32'(level), 32'(e_lvl));
        check_eq("model_pulse", 32'(pulse), 32'(e_pls));
        check_eq("model_any_pulse", 32'(any_pulse), 32'(|e_pls));
      end
    end
  end

  // Count edges until pulse[ch] or level[ch] equals val; budget+1 means timeout.
  task automatic wait_sig(input int ch, input bit use_pulse, input bit val, input int budget,
                          output int n);
    bit hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      @(posedge Clock);
      #2;
      n++;
      if ((use_pulse ? pulse[ch] : level[ch]) == val) hit = 1'b1;
    end
    if (!hit) n = budget + 1;
  endtask

  task automatic count_pulses(input int ch, input int edges, output int cnt);
    cnt = 0;
    repeat (edges) begin
      @(posedge Clock);
      #2;
      if (pulse[ch]) cnt++;
    end
  endtask

  task automatic drive_bit(input int ch, input bit v);
    @(negedge Clock);
    A[ch] = v;
  endtask

  initial begin
    int n;
    int cnt;
    int exp_rep;

    // Asynchronous reset with random inputs
    repeat (3) @(posedge Clock);
    #3;
    A = CH'($urandom);
    Reset = 1'b1;
    mon_en = 1'b1;
    #1;
    check_eq("reset_level", 32'(level), 32'(0));
    check_eq("reset_pulse", 32'(pulse), 32'(0));
    check_eq("reset_any_pulse", 32'(any_pulse), 32'(0));
    repeat (2) @(negedge Clock);
    A = '1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // Single press / release latency on channel 0
    drive_bit(0, 1'b0);
    wait_sig(0, 1'b1, 1'b1, 20, n);
    check_eq("press_latency", n, 6);
    check_eq("press_level", 32'(level[0]), 32'(1));
    @(posedge Clock);
    #2;
    check_eq("pulse_one_cycle", 32'(pulse[0]), 32'(0));
    drive_bit(0, 1'b1);
    wait_sig(0, 1'b0, 1'b0, 20, n);
    check_eq("release_latency", n, 6);
    count_pulses(0, 10, cnt);
    check_eq("release_no_pulse", cnt, 0);

    // Bounce on channel 1: toggle every 3 cycles for 30 cycles, then hold pressed
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge Clock);
      A[1] = ~A[1];
      repeat (3) begin
        @(posedge Clock);
        #2;
        if (pulse[1]) cnt++;
      end
    end
    check_eq("bounce_no_pulse", cnt, 0);
    drive_bit(1, 1'b0);
    wait_sig(1, 1'b1, 1'b1, 20, n);
    check_eq("bounce_settle_latency", n, 6);
    count_pulses(1, 10, cnt);
    check_eq("bounce_single_pulse", cnt, 0);
    drive_bit(1, 1'b1);
    repeat (10) @(negedge Clock);

    // Simultaneous press on channels 0 and 2
    @(negedge Clock);
    A[0] = 1'b0;
    A[2] = 1'b0;
    wait_sig(0, 1'b1, 1'b1, 20, n);
    check_eq("simul_latency", n, 6);
    check_eq("simul_pulse2", 32'(pulse[2]), 32'(1));
    check_eq("simul_any_pulse", 32'(any_pulse), 32'(1));
    check_eq("simul_idle_pulse", 32'({pulse[3], pulse[1]}), 32'(0));
    check_eq("simul_idle_level", 32'({level[3], level[1]}), 32'(0));
    @(negedge Clock);
    A[0] = 1'b1;
    A[2] = 1'b1;
    repeat (10) @(negedge Clock);

    // Reset mid-count on channel 3, key held through reset
    drive_bit(3, 1'b0);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_eq("midreset_level", 32'(level), 32'(0));
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    wait_sig(3, 1'b1, 1'b1, 20, n);
    check_eq("midreset_latency", n, 6);
    count_pulses(3, 10, cnt);
    check_eq("midreset_single_pulse", cnt, 0);
    drive_bit(3, 1'b1);
    repeat (10) @(negedge Clock);

    // Long hold on channel 0: repeat pulses only in the repeat build
`ifdef INPUT_COND_REPEAT_EN
    exp_rep = 7;
`else
    exp_rep = 0;
`endif
    drive_bit(0, 1'b0);
    wait_sig(0, 1'b1, 1'b1, 20, n);
    check_eq("hold_first_latency", n, 6);
    count_pulses(0, 40, cnt);
    check_eq("hold_repeat_count", cnt, exp_rep);
    drive_bit(0, 1'b1);
    wait_sig(0, 1'b0, 1'b0, 20, n);
    check_eq("hold_release_latency", n, 6);
    count_pulses(0, 20, cnt);
    check_eq("hold_after_release", cnt, 0);

    // Random stimulus with occasional resets, checked by the scoreboard
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge Clock);
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) Reset = 1'b1;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, ((cyc / 250) % 2 == 0) ? 7 : 40) == 0) A[c] = ~A[c];
      end
    end
    @(negedge Clock);
    Reset = 1'b0;
    A = '1;
    repeat (12) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
